// File: rtl/synapse_current_integrator.sv
// synapse_current_integrator: weighted, exponentially decaying synaptic current for the spike-initiation neuron.
// Optional build macro SYN_SATURATE_EN clamps the current at all-ones instead of wrapping modulo 2^DATA_LENGTH.
module synapse_current_integrator #(
    parameter int DATA_LENGTH = 16,
    parameter int N_INPUTS    = 8,
    parameter int ADDR_W      = 4,
    parameter int TAU_SHIFT   = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_INPUTS-1:0]    i_pre_spike,
    input  logic                   i_wr_en,
    input  logic [ADDR_W-1:0]      i_wr_addr,
    input  logic [DATA_LENGTH-1:0] i_wr_data,
    output logic                   o_wr_ack,
    output logic [DATA_LENGTH-1:0] o_current,
    output logic                   o_active
);

    // One spare bit above the full weight sum so adding the old current cannot overflow either.
    localparam int WIDE_W = DATA_LENGTH + $clog2(N_INPUTS) + 1;

    logic [DATA_LENGTH-1:0] w_q [N_INPUTS];
    logic [DATA_LENGTH-1:0] w_d [N_INPUTS];
    logic [DATA_LENGTH-1:0] cur_q, cur_d, dec;
    logic                   act_q, act_d, ack_q, ack_d, wr_ok;
    logic [WIDE_W-1:0]      sum, nxt;

    // Weight table write decode; out-of-range addresses are ignored and not acknowledged.
    always_comb begin
        wr_ok = i_wr_en && (32'(i_wr_addr) < N_INPUTS);
        ack_d = wr_ok;
        w_d   = w_q;
        for (int k = 0; k < N_INPUTS; k++)
            if (wr_ok && 32'(i_wr_addr) == k) w_d[k] = i_wr_data;
    end

    // Sum the pre-write weights of every spiking input and apply decay with a floor of one step.
    always_comb begin
        sum = '0;
        for (int k = 0; k < N_INPUTS; k++)
            if (i_pre_spike[k]) sum = sum + WIDE_W'(w_q[k]);
        dec   = ((cur_q >> TAU_SHIFT) == '0 && cur_q != '0) ? DATA_LENGTH'(1) : (cur_q >> TAU_SHIFT);
        nxt   = WIDE_W'(cur_q) - WIDE_W'(dec) + sum;
        act_d = |i_pre_spike;
    end

`ifdef SYN_SATURATE_EN
    // Clamp to all-ones whenever the wide result exceeds the output range.
    always_comb begin
        cur_d = (|nxt[WIDE_W-1:DATA_LENGTH]) ? '1 : nxt[DATA_LENGTH-1:0];
    end
`else
    logic unused_hi;
    // Keep only the low bits, wrapping modulo 2^DATA_LENGTH.
    always_comb begin
        cur_d     = nxt[DATA_LENGTH-1:0];
        unused_hi = ^nxt[WIDE_W-1:DATA_LENGTH];
    end
`endif

    // State registers; reset clears the weights and the accumulated current.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            w_q   <= '{default: '0};
            cur_q <= '0;
            act_q <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            w_q   <= w_d;
            cur_q <= cur_d;
            act_q <= act_d;
            ack_q <= ack_d;
        end
    end

    assign o_current = cur_q;
    assign o_active  = act_q;
    assign o_wr_ack  = ack_q;

endmodule

// File: tb/tb_synapse_current_integrator.sv
// tb_synapse_current_integrator: directed scoreboard bench for synapse_current_integrator.
module tb_synapse_current_integrator;

    localparam int DL = 16;
    localparam int N  = 8;
    localparam int AW = 4;
    localparam int TS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  pre = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DL-1:0] wr_data = '0;
    logic          ack;
    logic [DL-1:0] cur;
    logic          act;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [DL-1:0] cur;
        logic          act;
        logic          ack;
    } exp_t;

    exp_t          sbq[$];
    logic [DL-1:0] m_w [N];
    logic [DL-1:0] m_cur = '0;

    synapse_current_integrator #(
        .DATA_LENGTH(DL), .N_INPUTS(N), .ADDR_W(AW), .TAU_SHIFT(TS)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_pre_spike(pre), .i_wr_en(wr_en),
        .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(ack),
        .o_current(cur), .o_active(act)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, push the model's prediction, then pop and compare after the edge.
    task automatic cyc(input logic r, input logic [N-1:0] s, input logic we,
                       input logic [AW-1:0] a, input logic [DL-1:0] d);
        exp_t          e;
        logic [20:0]   nx;
        logic [DL-1:0] dc;
        int            ai;
        ai = int'(a);
        e  = '0;
        if (!r) begin
            nx = '0;
            for (int k = 0; k < N; k++) if (s[k]) nx = nx + 21'(m_w[k]);
            dc = m_cur >> TS;
            if (dc == 0 && m_cur != 0) dc = 1;
            nx = nx + 21'(m_cur) - 21'(dc);
`ifdef SYN_SATURATE_EN
            e.cur = (nx > 21'd65535) ? 16'hFFFF : nx[15:0];
`else
            e.cur = nx[15:0];
`endif
            e.act = |s;
            e.ack = we && ai < N;
        end
        sbq.push_back(e);
        rst = r; pre = s; wr_en = we; wr_addr = a; wr_data = d;
        @(posedge clk);
        #1;
        if (r) begin
            m_cur = '0;
            for (int k = 0; k < N; k++) m_w[k] = '0;
        end else begin
            m_cur = e.cur;
            if (we && ai < N) m_w[ai] = d;
        end
        e = sbq.pop_front();
        chk("current", 32'(cur), 32'(e.cur));
        chk("active", 32'(act), 32'(e.act));
        chk("wr_ack", 32'(ack), 32'(e.ack));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DL-1:0] d);
        cyc(1'b0, '0, 1'b1, a, d);
    endtask

    task automatic spike(input logic [N-1:0] s);
        cyc(1'b0, s, 1'b0, '0, '0);
    endtask

    initial begin
        static int decay_exp[5] = '{75, 57, 43, 33, 25};
        for (int k = 0; k < N; k++) m_w[k] = '0;
        cyc(1'b1, '0, 1'b0, '0, '0);
        cyc(1'b1, '0, 1'b0, '0, '0);
        chk("reset_current", 32'(cur), 0);
        chk("reset_ack", 32'(ack), 0);

        wr(4'd0, 16'd100);
        chk("write_ack_pulse", 32'(ack), 1);
        spike(8'h01);
        chk("decay_peak", 32'(cur), 100);
        chk("ack_single", 32'(ack), 0);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("decay_step", 32'(cur), 32'(decay_exp[i]));
        end
        idle(25);
        chk("decay_zero", 32'(cur), 0);
        idle(3);
        chk("decay_hold", 32'(cur), 0);

        wr(4'd1, 16'd5);
        wr(4'd2, 16'd7);
        chk("b2b_ack", 32'(ack), 1);
        spike(8'h06);
        chk("multi_sum", 32'(cur), 12);
        chk("multi_active", 32'(act), 1);
        idle(1);
        chk("multi_decay", 32'(cur), 9);
        chk("multi_inactive", 32'(act), 0);
        idle(12);

        wr(4'd3, 16'd10);
        cyc(1'b0, 8'h08, 1'b1, 4'd3, 16'd20);
        chk("collision_old", 32'(cur), 10);
        spike(8'h08);
        chk("collision_new", 32'(cur), 28);
        idle(20);

        wr(4'd9, 16'h1234);
        chk("oor_no_ack", 32'(ack), 0);
        spike(8'hFF);
        chk("oor_sum", 32'(cur), 132);
        idle(30);

        for (int k = 0; k < N; k++) wr(AW'(k), 16'hFFFF);
        spike(8'hFF);
`ifdef SYN_SATURATE_EN
        chk("overflow", 32'(cur), 65535);
`else
        chk("overflow", 32'(cur), 65528);
`endif
        idle(70);
        chk("overflow_drain", 32'(cur), 0);

        wr(4'd0, 16'd500);
        spike(8'h01);
        chk("pre_reset", 32'(cur), 500);
        cyc(1'b1, 8'hFF, 1'b0, '0, '0);
        chk("mid_reset_current", 32'(cur), 0);
        chk("mid_reset_active", 32'(act), 0);
        spike(8'hFF);
        chk("post_reset_weights", 32'(cur), 0);
        wr(4'd5, 16'd40);
        spike(8'h20);
        chk("rewritten", 32'(cur), 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
